mem_resp_pipe: RTL and testbench
================================

# mem_resp_pipe

Pipelined word-memory responder: the memory-side end of the CPU's enable/wr/addr/data_in/data_out memory port. It accepts one request per cycle and commits writes immediately. Read data returns after a fixed `LATENCY`, qualified by `data_valid`. It is the multi-cycle replacement for the single-cycle instruction and data memories; up to `LATENCY` reads may be in flight.

## Interface
- `LATENCY`, 4, cycles from a read request to its data; legal range 1..7.
- `DEPTH_LOG2`, 10, log2 of stored 16-bit words.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  request valid this cycle.
- `wr`  in  1  1 = write, 0 = read; meaningful only when `enable`=1.
- `addr`  in  16  byte address. Word index is `addr[DEPTH_LOG2:1]`. `addr[0]` and bits above `DEPTH_LOG2` are ignored (addresses alias).
- `data_in`  in  16  write data.
- `data_out`  out  16  read data; valid only when `data_valid`=1, otherwise 0.
- `data_valid`  out  1  read response strobe, one cycle per accepted read.
- `rd_pending`  out  3  reads accepted but not yet returned.

## Operation
- **Acceptance.** A request is accepted at the rising edge where `enable`=1. There is no back-pressure; every cycle can carry a request.
- **Write.**
  - `mem[idx] <= data_in` at the acceptance edge.
  - No response is generated, and `rd_pending` is unaffected.
- **Read.**
  - The array is sampled at the acceptance edge. It therefore sees every write accepted at an earlier edge, but not a write in the same cycle (only one request per cycle exists).
  - The sampled word plus a valid bit enter a `LATENCY`-deep shift pipeline; the last stage drives `data_out` and `data_valid`.
- **Ignored inputs.** `enable`=0 is ignored regardless of `wr`, `addr` and `data_in`; no state changes.
- **`rd_pending` update, per edge:**
  - +1 on read acceptance.
  - −1 when `data_valid`=1 in the ending cycle.
  - Both together leave it unchanged.
  - It never exceeds `LATENCY` and never underflows.
- **Reset.**
  - Clears all pipeline valid bits and data stages and sets `rd_pending` to 0.
  - A request presented in a reset cycle is ignored, including writes.
  - Array contents are not cleared; a loaded image survives reset.
- **Reset mid-operation.** All in-flight reads are dropped; no `data_valid` follows for them. Writes already committed remain.
- **Outputs after reset.** `data_out`=0, `data_valid`=0, `rd_pending`=0.

## Timing
- A read presented in cycle k (sampled at the edge ending k) yields `data_valid`=1 and the data throughout cycle k+`LATENCY`.
- With `LATENCY`=1 this matches a synchronous-read memory.
- Back-to-back reads in cycles k, k+1, k+2 produce `data_valid` in k+L, k+L+1, k+L+2, in order, with no bubbles.
- `data_out` is a registered output with no combinational input-to-output path.
- Read-after-write:
  - Write in cycle k, read of the same address in cycle k+1: the read returns the new data.
  - Read in cycle k, write in cycle k+1: the read returns the old data.
- Steady state of one read per cycle: `rd_pending` holds at `LATENCY`.

## Test plan
- **Reset values.** Hold `rst`=1 for 2 cycles with `enable`=1, `wr`=1, `addr`=0x0010, `data_in`=0xBEEF → `data_out`=0, `data_valid`=0, `rd_pending`=0. A later read of 0x0010 returns its pre-reset value, not 0xBEEF.
- **RAW ordering.** Write 0x1234 to 0x0020 in cycle 0, read 0x0020 in cycle 1 → `data_valid`=1 with `data_out`=0x1234 in cycle 5 (`LATENCY`=4). A read of 0x0020 in cycle 0 before a write of 0x5678 in cycle 1 → returns 0x1234.
- **Streaming.** Preload words 0..7 with 0xA000+i, then read addrs 0x0,0x2,…,0xE in consecutive cycles 0..7 → `data_valid` high in cycles 4..11 with 0xA000..0xA007 in order; `rd_pending` reads 1,2,3,4,4,4,4,4 in cycles 1..8, then 3,2,1,0 in cycles 9..12.
- **Aliasing.** Write 0xCAFE to addr 0x0004, read addr 0x0005 and addr 0x0804 (`DEPTH_LOG2`=10) → both return 0xCAFE.
- **Ignored requests.** Drive `enable`=0, `wr`=1, `addr`=0x0004, `data_in`=0xFFFF for 3 cycles → a later read of 0x0004 returns the prior value, and no `data_valid` pulses occur during those cycles.
- **Reset mid-flight.** Issue reads in cycles 0..2 and assert `rst` in cycle 3 → no `data_valid` in cycles 4..6, and `rd_pending`=0 from cycle 4. A read issued in cycle 5 returns normally in cycle 9.

Source files
------------

// File: rtl/mem_resp_pipe_if.sv
// rtl/mem_resp_pipe_if.sv - request/response bundle for the pipelined word-memory responder
interface mem_resp_pipe_if;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic [2:0]  rd_pending;

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, data_valid, rd_pending
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, data_valid, rd_pending
    );
endinterface

// File: rtl/mem_resp_pipe.sv
// rtl/mem_resp_pipe.sv - word memory with immediate writes and fixed-latency pipelined reads
module mem_resp_pipe #(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic          clk,
    input  logic          rst,
    mem_resp_pipe_if.slave bus
);
    localparam int WORDS = 1 << DEPTH_LOG2;

    logic [15:0]           mem [WORDS];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  rd_accept;
    logic                  wr_accept;
    logic [15:0]           pipe_data [LATENCY];
    logic [LATENCY-1:0]    pipe_valid;
    logic [2:0]            pending;

    // Byte address to word index; addr[0] and high bits alias.
    assign idx       = bus.addr[DEPTH_LOG2:1];
    assign rd_accept = bus.enable && !bus.wr && !rst;
    assign wr_accept = bus.enable &&  bus.wr && !rst;

    generate
        if (DEPTH_LOG2 < 15) begin : g_hi_alias
            logic unused_addr_bits;
            assign unused_addr_bits = ^{bus.addr[15:DEPTH_LOG2+1], bus.addr[0]};
        end else begin : g_no_hi_alias
            logic unused_addr_bits;
            assign unused_addr_bits = bus.addr[0];
        end
    endgenerate

    // Array contents are deliberately outside reset so a loaded image survives it.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[idx] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
            pending <= '0;
        end else begin
            // Idle stages carry zero data so data_out is 0 whenever data_valid is 0.
            pipe_valid[0] <= rd_accept;
            pipe_data[0]  <= rd_accept ? mem[idx] : 16'h0000;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
            case ({rd_accept, pipe_valid[LATENCY-1]})
                2'b10:   pending <= pending + 3'd1;
                2'b01:   pending <= pending - 3'd1;
                default: pending <= pending;
            endcase
        end
    end

    assign bus.data_out   = pipe_data[LATENCY-1];
    assign bus.data_valid = pipe_valid[LATENCY-1];
    assign bus.rd_pending = pending;
endmodule

// File: tb/tb_mem_resp_pipe.sv
// tb/tb_mem_resp_pipe.sv - directed table-driven bench for mem_resp_pipe
module tb_mem_resp_pipe;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_resp_pipe_if bus ();

    mem_resp_pipe #(.LATENCY(LAT), .DEPTH_LOG2(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        r;
        logic        en;
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
        logic        chk;
        logic        ev;
        logic [15:0] ed;
        logic [2:0]  ep;
    } vec_t;

    vec_t vecs[$];
    int   applied     = 0;
    int   miscompares = 0;

    task automatic add(input logic r, en, w, input logic [15:0] a, d,
                       input logic chk, ev, input logic [15:0] ed, input logic [2:0] ep);
        vec_t v;
        v.r = r; v.en = en; v.w = w; v.a = a; v.d = d;
        v.chk = chk; v.ev = ev; v.ed = ed; v.ep = ep;
        vecs.push_back(v);
    endtask

    // One clock cycle: inputs held from just after an edge, outputs sampled mid-cycle.
    task automatic cycle(input string name, input logic r, en, w, input logic [15:0] a, d,
                         input logic chk, ev, input logic [15:0] ed, input logic [2:0] ep);
        rst = r; bus.enable = en; bus.wr = w; bus.addr = a; bus.data_in = d;
        @(negedge clk);
        if (chk) begin
            applied++;
            if (bus.data_valid !== ev || bus.data_out !== ed || bus.rd_pending !== ep) begin
                miscompares++;
                $display("FAIL %s: got valid=%b data=%h pending=%0d, want valid=%b data=%h pending=%0d",
                         name, bus.data_valid, bus.data_out, bus.rd_pending, ev, ed, ep);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, applied=%0d", applied);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; bus.enable = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.data_in = '0;
        @(posedge clk);
        #1;

        // Reset values; memory preset before reset must survive it.
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0);
        add(0, 1, 1, 16'h0010, 16'h1111, 1, 0, 16'h0000, 0);
        add(1, 1, 1, 16'h0010, 16'hBEEF, 1, 0, 16'h0000, 0);
        add(1, 1, 1, 16'h0010, 16'hBEEF, 1, 0, 16'h0000, 0);
        add(0, 1, 0, 16'h0010, 16'h0000, 1, 0, 16'h0000, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 1);
        add(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h1111, 1);
        add(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0);

        // Read-after-write and write-after-read ordering.
        add(0, 1, 1, 16'h0020, 16'h1234, 1, 0, 16'h0000, 0);
        add(0, 1, 0, 16'h0020, 16'h0000, 1, 0, 16'h0000, 0);
        add(0, 1, 0, 16'h0020, 16'h0000, 1, 0, 16'h0000, 1);
        add(0, 1, 1, 16'h0020, 16'h5678, 1, 0, 16'h0000, 2);
        add(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 2);
        add(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h1234, 2);
        add(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h1234, 1);
        add(0, 1, 0, 16'h0020, 16'h0000, 1, 0, 16'h0000, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 1);
        add(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h5678, 1);

        // Streaming: preload then eight back-to-back reads.
        for (int i = 0; i < 8; i++)
            add(0, 1, 1, 16'(2 * i), 16'(16'hA000 + i), 1, 0, 16'h0000, 0);
        for (int s = 0; s <= 12; s++) begin
            logic [2:0] ep;
            ep = (s <= 8) ? 3'((s < 4) ? s : 4) : 3'(12 - s);
            if (s >= 4 && s <= 11)
                add(0, (s < 8), 0, 16'(2 * s), 16'h0000, 1, 1, 16'(16'hA000 + s - 4), ep);
            else
                add(0, (s < 8), 0, 16'(2 * s), 16'h0000, 1, 0, 16'h0000, ep);
        end

        // Aliasing: addr[0] and bits above the index are ignored.
        add(0, 1, 1, 16'h0004, 16'hCAFE, 1, 0, 16'h0000, 0);
        add(0, 1, 0, 16'h0005, 16'h0000, 1, 0, 16'h0000, 0);
        add(0, 1, 0, 16'h0804, 16'h0000, 1, 0, 16'h0000, 1);
        add(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 2);
        add(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 2);
        add(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'hCAFE, 2);
        add(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'hCAFE, 1);
        add(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0);

        foreach (vecs[i]) begin
            cycle($sformatf("row%0d", i), vecs[i].r, vecs[i].en, vecs[i].w, vecs[i].a, vecs[i].d,
                  vecs[i].chk, vecs[i].ev, vecs[i].ed, vecs[i].ep);
        end

        // Ignored requests: enable low with write-looking inputs changes nothing.
        for (int i = 0; i < 3; i++)
            cycle("ignored_idle", 0, 0, 1, 16'h0004, 16'hFFFF, 1, 0, 16'h0000, 0);
        cycle("ignored_rd", 0, 1, 0, 16'h0004, 16'h0000, 1, 0, 16'h0000, 0);
        for (int i = 0; i < 3; i++)
            cycle("ignored_wait", 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 1);
        cycle("ignored_data", 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'hCAFE, 1);
        cycle("ignored_done", 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0);

        // Reset mid-flight drops in-flight reads; a later read proceeds normally.
        cycle("midrst_rd0", 0, 1, 0, 16'h0010, 16'h0000, 1, 0, 16'h0000, 0);
        cycle("midrst_rd1", 0, 1, 0, 16'h0010, 16'h0000, 1, 0, 16'h0000, 1);
        cycle("midrst_rd2", 0, 1, 0, 16'h0010, 16'h0000, 1, 0, 16'h0000, 2);
        cycle("midrst_rst", 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 3);
        cycle("midrst_c4",  0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0);
        cycle("midrst_c5",  0, 1, 0, 16'h0020, 16'h0000, 1, 0, 16'h0000, 0);
        cycle("midrst_c6",  0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 1);
        cycle("midrst_c7",  0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 1);
        cycle("midrst_c8",  0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 1);
        cycle("midrst_c9",  0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h5678, 1);
        cycle("midrst_c10", 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
